// File: rtl/ov7670_rgb_capture_pkg.sv
// cap_pkg: shared FSM encoding, frame geometry defaults and RGB565->RGB444 packing
// for the OV7670 capture path.
package cap_pkg;
    typedef enum logic [1:0] {WAIT_VS, VS_HIGH, ACTIVE} cap_state_e;
    localparam int H_PIX_DEF   = 320;
    localparam int V_LINES_DEF = 240;
    localparam int R_LSB = 8;
    localparam int G_LSB = 4;
    localparam int B_LSB = 0;
    // Keep the top four bits of each channel; green drops its extra LSB as well.
    function automatic logic [11:0] rgb565_to_444(input logic [15:0] d);
        logic [11:0] p;
        p = '0;
        p[R_LSB +: 4] = d[15:12];
        p[G_LSB +: 4] = d[10:7];
        p[B_LSB +: 4] = d[4:1];
        return p;
    endfunction
endpackage

// File: rtl/ov7670_rgb_capture_byte_pair.sv
// cap_byte_pair: pairs href bytes into 16-bit pixels and counts bytes per href run;
// line_bad flags the run end when the count is not a full line.
module cap_byte_pair #(
    parameter int H_PIX = 320
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        href,
    input  logic [7:0]  d,
    output logic        pix_valid,
    output logic [15:0] d16,
    output logic        line_bad
);
    localparam int LB = 2 * H_PIX;
    localparam int CW = $clog2(LB + 2);
    localparam logic [CW-1:0] LB_W  = CW'(LB);
    localparam logic [CW-1:0] SAT_W = CW'(LB + 1);
    logic          phase_q, href_q, pv_q;
    logic [7:0]    hi_q;
    logic [15:0]   d16_q;
    logic [CW-1:0] cnt_q;
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            phase_q <= 1'b0;
            href_q  <= 1'b0;
            pv_q    <= 1'b0;
            hi_q    <= '0;
            d16_q   <= '0;
            cnt_q   <= '0;
        end else begin
            href_q  <= href;
            phase_q <= href && !phase_q;
            hi_q    <= (href && !phase_q) ? d : hi_q;
            pv_q    <= href && phase_q;
            d16_q   <= (href && phase_q) ? {hi_q, d} : d16_q;
            // Saturate one past a full line so overlong runs stay distinguishable.
            cnt_q   <= !href ? '0 : (cnt_q == SAT_W) ? cnt_q : cnt_q + 1'b1;
        end
    end
    assign pix_valid = pv_q;
    assign d16       = d16_q;
    assign line_bad  = href_q && !href && (cnt_q != LB_W);
endmodule

// File: rtl/ov7670_rgb_capture.sv
// ov7670_rgb_capture: frames OV7670 RGB565 bytes into RGB444 frame-buffer writes.
// CAP_SKIP_FIRST_FRAME_EN suppresses writes for the first captured frame after reset.
module ov7670_rgb_capture
    import cap_pkg::*;
#(
    parameter int H_PIX   = H_PIX_DEF,
    parameter int V_LINES = V_LINES_DEF,
    parameter int ADDR_W  = 17
) (
    input  logic              cap_pclk,
    input  logic              cap_rst,
    input  logic              cap_vsync,
    input  logic              cap_href,
    input  logic [7:0]        cap_d,
    output logic              cap_we,
    output logic [ADDR_W-1:0] cap_addr,
    output logic [11:0]       cap_dout,
    output logic              frame_done,
    output logic              line_err,
    output logic              frame_err
);
`ifdef CAP_SKIP_FIRST_FRAME_EN
    localparam logic SKIP_RST = 1'b1;
`else
    localparam logic SKIP_RST = 1'b0;
`endif
    localparam logic [ADDR_W:0] TOTAL_W = (ADDR_W+1)'(H_PIX * V_LINES);
    cap_state_e        state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [11:0]       dout_q;
    logic              slot_q, we_q, done_q, lerr_q, ferr_q, skip_q;
    logic              pix_valid, line_bad;
    logic [15:0]       d16;
    logic              active, start, frame_end, full, pair_href;
    logic [ADDR_W:0]   n_pix;
    assign active    = state_q == ACTIVE;
    assign start     = (state_q == VS_HIGH) && !cap_vsync;
    assign frame_end = active && cap_vsync;
    assign pair_href = active && !cap_vsync && cap_href;
    assign full      = {1'b0, addr_q} == TOTAL_W;
    // Pixels still in the pipeline at frame end count toward the frame total.
    assign n_pix     = {1'b0, addr_q} + (ADDR_W+1)'(slot_q) + (ADDR_W+1)'(pix_valid);
    cap_byte_pair #(.H_PIX(H_PIX)) u_pair (
        .clk       (cap_pclk),
        .rst       (cap_rst),
        .clr       (start),
        .href      (pair_href),
        .d         (cap_d),
        .pix_valid (pix_valid),
        .d16       (d16),
        .line_bad  (line_bad)
    );
    always_ff @(posedge cap_pclk) begin
        if (cap_rst) begin
            state_q <= WAIT_VS;
            addr_q  <= '0;
            dout_q  <= '0;
            slot_q  <= 1'b0;
            we_q    <= 1'b0;
            done_q  <= 1'b0;
            lerr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            skip_q  <= SKIP_RST;
        end else begin
            case (state_q)
                WAIT_VS: state_q <= cap_vsync ? VS_HIGH : WAIT_VS;
                VS_HIGH: state_q <= cap_vsync ? VS_HIGH : ACTIVE;
                ACTIVE:  state_q <= cap_vsync ? VS_HIGH : ACTIVE;
                default: state_q <= WAIT_VS;
            endcase
            addr_q <= start ? '0 : addr_q + ADDR_W'(slot_q);
            slot_q <= pix_valid && !full;
            we_q   <= pix_valid && !full && !skip_q;
            dout_q <= pix_valid ? rgb565_to_444(d16) : dout_q;
            done_q <= frame_end;
            lerr_q <= lerr_q | line_bad;
            ferr_q <= ferr_q | (pix_valid && full) | (frame_end && (n_pix != TOTAL_W));
            skip_q <= skip_q && !frame_end;
        end
    end
    assign cap_we     = we_q;
    assign cap_addr   = addr_q;
    assign cap_dout   = dout_q;
    assign frame_done = done_q;
    assign line_err   = lerr_q;
    assign frame_err  = ferr_q;
endmodule

// File: tb/tb_ov7670_rgb_capture.sv
// tb_ov7670_rgb_capture: directed frames on a reduced 8x4 geometry; expected writes
// are queued at stimulus time and checked by an independent write monitor.
module tb_ov7670_rgb_capture;
    localparam int H = 8;
    localparam int V = 4;
    localparam int AW = 8;
    localparam int TOTAL = H * V;
`ifdef CAP_SKIP_FIRST_FRAME_EN
    localparam bit SKIP_RST = 1'b1;
`else
    localparam bit SKIP_RST = 1'b0;
`endif
    localparam int FIRST_WR = SKIP_RST ? 0 : TOTAL;
    typedef struct packed {
        logic [AW-1:0] a;
        logic [11:0]   px;
    } exp_t;
    logic clk = 1'b0, rst = 1'b1, vs = 1'b0, href = 1'b0;
    logic [7:0] d = '0;
    logic cap_we, frame_done, line_err, frame_err;
    logic [AW-1:0] cap_addr;
    logic [11:0] cap_dout;
    exp_t q[$];
    exp_t e;
    int errors = 0, checks = 0, done_cnt = 0, writes = 0, pushed = 0, exp_addr = 0;
    bit cap_on = 1'b0, skip = 1'b0, lat = 1'b0;
    logic [15:0] pat_in[5]  = '{16'hF800, 16'h07E0, 16'h001F, 16'hFFFF, 16'h1234};
    logic [11:0] pat_out[5] = '{12'hF00, 12'h0F0, 12'h00F, 12'hFFF, 12'h14A};

    ov7670_rgb_capture #(.H_PIX(H), .V_LINES(V), .ADDR_W(AW)) dut (
        .cap_pclk   (clk),
        .cap_rst    (rst),
        .cap_vsync  (vs),
        .cap_href   (href),
        .cap_d      (d),
        .cap_we     (cap_we),
        .cap_addr   (cap_addr),
        .cap_dout   (cap_dout),
        .frame_done (frame_done),
        .line_err   (line_err),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (cap_we) begin
            writes++;
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: addr=%0d dout=%03h, no write expected", cap_addr, cap_dout);
            end else begin
                e = q.pop_front();
                if (cap_addr !== e.a || cap_dout !== e.px) begin
                    errors++;
                    $display("FAIL write: addr=%0d dout=%03h, expected addr=%0d dout=%03h",
                             cap_addr, cap_dout, e.a, e.px);
                end
            end
        end
        if (frame_done) done_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; vs = 1'b0; href = 1'b0;
        tick(2);
        rst = 1'b0;
        cap_on = 1'b0;
        skip = SKIP_RST;
    endtask

    task automatic vsync_pulse(input bit with_href);
        @(negedge clk);
        vs = 1'b1; href = with_href;
        if (cap_on) skip = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            d = 8'(i * 37);
        end
        vs = 1'b0; href = 1'b0;
        cap_on = 1'b1;
        exp_addr = 0;
        tick(4);
    endtask

    task automatic send_line(input int nbytes, input bit colour, input int rst_at);
        int k;
        k = 0;
        for (int i = 0; i < nbytes; i++) begin
            @(negedge clk);
            if (lat && i == 2) check("lat_we_early", cap_we, 0);
            if (lat && i == 3) begin
                check("lat_we", cap_we, 1);
                check("lat_addr", cap_addr, 0);
            end
            if (lat && i == 4) check("lat_addr_adv", cap_addr, 1);
            if (i == rst_at) begin
                rst = 1'b1; cap_on = 1'b0; skip = SKIP_RST;
            end else if (i == rst_at + 1) rst = 1'b0;
            if (i % 2 == 0) k = colour ? exp_addr % 5 : 0;
            href = 1'b1;
            d = (i % 2 == 0) ? pat_in[k][15:8] : pat_in[k][7:0];
            if (i % 2 == 1 && cap_on) begin
                if (!skip && exp_addr < TOTAL) begin
                    q.push_back('{a: AW'(exp_addr), px: pat_out[k]});
                    pushed++;
                end
                exp_addr++;
            end
        end
        @(negedge clk);
        href = 1'b0; rst = 1'b0; lat = 1'b0;
        tick(4);
    endtask

    task automatic frame(input int lines, input bit colour);
        for (int l = 0; l < lines; l++) send_line(2 * H, colour, -1);
    endtask

    initial begin
        do_reset();
        check("rst_we", cap_we, 0);
        check("rst_addr", cap_addr, 0);
        check("rst_dout", cap_dout, 0);
        check("rst_done", frame_done, 0);
        check("rst_line_err", line_err, 0);
        check("rst_frame_err", frame_err, 0);
        // Normal frame, then a vsync pulse carrying href bytes that must be ignored.
        vsync_pulse(1'b0);
        frame(V, 1'b0);
        vsync_pulse(1'b1);
        check("t1_writes", writes, FIRST_WR);
        check("t1_done", done_cnt, 1);
        check("t1_line_err", line_err, 0);
        check("t1_frame_err", frame_err, 0);
        check("t1_queue", q.size(), 0);
        // Colour table frame with write latency probes on the first pixel.
        lat = !skip;
        frame(V, 1'b1);
        vsync_pulse(1'b0);
        check("t2_writes", writes, pushed);
        check("t2_done", done_cnt, 2);
        check("t2_frame_err", frame_err, 0);
        check("t2_queue", q.size(), 0);
        // Line 1 carries an odd 15 bytes; the trailing byte is dropped.
        send_line(2 * H, 1'b0, -1);
        check("t3_line_err_pre", line_err, 0);
        send_line(2 * H - 1, 1'b0, -1);
        check("t3_line_err", line_err, 1);
        check("t3_frame_err_pre", frame_err, 0);
        frame(V - 2, 1'b1);
        vsync_pulse(1'b0);
        check("t3_frame_err", frame_err, 1);
        check("t3_done", done_cnt, 3);
        check("t3_writes", writes, pushed);
        check("t3_queue", q.size(), 0);
        // Overflow: one extra line beyond the frame.
        do_reset();
        check("t4_line_err_clr", line_err, 0);
        check("t4_frame_err_clr", frame_err, 0);
        vsync_pulse(1'b0);
        frame(V + 1, 1'b0);
        check("t4_addr_sat", cap_addr, TOTAL);
        check("t4_frame_err", frame_err, 1);
        check("t4_line_err", line_err, 0);
        check("t4_writes", writes, pushed);
        vsync_pulse(1'b0);
        check("t4_done", done_cnt, 4);
        // Reset mid-line, href resumes without vsync, then a clean frame.
        do_reset();
        vsync_pulse(1'b0);
        frame(2, 1'b0);
        send_line(2 * H, 1'b0, 7);
        send_line(2 * H, 1'b1, -1);
        check("t5_no_writes", writes, pushed);
        check("t5_queue_mid", q.size(), 0);
        check("t5_done_mid", done_cnt, 4);
        check("t5_addr_mid", cap_addr, 0);
        vsync_pulse(1'b0);
        frame(V, 1'b1);
        vsync_pulse(1'b0);
        check("t5_done", done_cnt, 5);
        check("t5_frame_err", frame_err, 0);
        check("t5_line_err", line_err, 0);
        check("t5_writes", writes, pushed);
        check("t5_queue", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
